display_bcd_8bits: RTL and testbench



---
 rtl/display_bcd_8bits_pkg.sv | 35 +++
 rtl/display_bcd_8bits_bcd_to_seg7.sv | 27 ++
 rtl/display_bcd_8bits.sv | 130 +++++++++++++
 tb/tb_display_bcd_8bits.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/display_bcd_8bits_pkg.sv
// Shared encodings for the 8-bit BCD display: FSM states, active-low gfedcba
// segment patterns, anode reset pattern and the double-dabble nibble adjust.
package display_bcd_8bits_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    localparam int NUM_DIGITS = 3;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [2:0] AN_IDLE = 3'b110;

    // Any nibble >= 5 gets +3 so the following left shift carries into the next digit.
    function automatic logic [11:0] dd_adjust(input logic [11:0] w);
        logic [11:0] r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[i*4 +: 4] = (w[i*4 +: 4] >= 4'd5) ? w[i*4 +: 4] + 4'd3 : w[i*4 +: 4];
        end
        return r;
    endfunction

endpackage

// File: rtl/display_bcd_8bits_bcd_to_seg7.sv
// Combinational BCD digit to active-low gfedcba 7-segment decoder;
// codes 10..15 decode to a blank digit.
module bcd_to_seg7
    import display_bcd_8bits_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_bcd_8bits.sv
// Binary-to-BCD (sequential double-dabble) converter driving a 3-digit multiplexed
// active-low 7-segment display. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module display_bcd_8bits
    import display_bcd_8bits_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value_in,
    output logic             busy,
    output logic [11:0]      bcd_out,
    output logic [2:0]       an,
    output logic [6:0]       seg
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    state_t           state, state_nxt;
    logic             start, done;
    logic [WIDTH-1:0] last_sampled;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [11:0]      work, work_adj, work_nxt;
    logic [2:0]       cnt;
    logic [PW-1:0]    presc;
    logic [1:0]       idx;
    logic [3:0]       digit;
    logic             blank;
    logic [6:0]       seg_dec;

    assign busy      = (state == CONV);
    assign work_adj  = dd_adjust(work);
    assign work_nxt  = {work_adj[10:0], shift_reg[WIDTH-1]};
    assign shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (value_in != last_sampled) begin
                    start     = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == 3'd7) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Conversion datapath: bcd_out only changes on the final shift, so an abort leaves it clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_sampled <= '0;
            shift_reg    <= '0;
            work         <= '0;
            cnt          <= '0;
            bcd_out      <= '0;
        end else if (start) begin
            last_sampled <= value_in;
            shift_reg    <= value_in;
            work         <= '0;
            cnt          <= '0;
        end else if (state == CONV) begin
            work      <= work_nxt;
            shift_reg <= shift_nxt;
            cnt       <= cnt + 3'd1;
            if (done) bcd_out <= work_nxt;
        end
    end

    // Digit scan runs freely, independent of the converter.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PRESC_MAX) begin
            presc <= '0;
            idx   <= (idx == 2'(NUM_DIGITS - 1)) ? 2'd0 : idx + 2'd1;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_comb begin
        digit = '0;
        blank = 1'b0;
        case (idx)
            2'd0:    digit = bcd_out[3:0];
            2'd1:    digit = bcd_out[7:4];
            default: digit = bcd_out[11:8];
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        case (idx)
            2'd1:    blank = (bcd_out[11:8] == 4'd0) && (bcd_out[7:4] == 4'd0);
            2'd2:    blank = (bcd_out[11:8] == 4'd0);
            default: blank = 1'b0;
        endcase
`endif
    end

    bcd_to_seg7 u_dec (
        .bcd (digit),
        .seg (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_IDLE;
            seg <= SEG_0;
        end else begin
            an  <= ~(3'b001 << idx);
            seg <= blank ? SEG_BLANK : seg_dec;
        end
    end

endmodule

// File: tb/tb_display_bcd_8bits.sv
// Scoreboard bench for display_bcd_8bits (SCAN_DIV=4): conversion results, latency,
// back-to-back handling, mid-conversion reset and the digit scan / blanking.
module tb_display_bcd_8bits;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  value_in;
    logic        busy;
    logic [11:0] bcd_out;
    logic [2:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int fails  = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    display_bcd_8bits #(.WIDTH(8), .SCAN_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .value_in (value_in),
        .busy     (busy),
        .bcd_out  (bcd_out),
        .an       (an),
        .seg      (seg)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [11:0] b, input int pos);
        logic [3:0] h, t, u;
        h = b[11:8]; t = b[7:4]; u = b[3:0];
`ifdef LEADING_ZERO_BLANK_EN
        if (pos == 2 && h == 4'd0) return 7'b1111111;
        if (pos == 1 && h == 4'd0 && t == 4'd0) return 7'b1111111;
`endif
        if (pos == 2) return seg_of(h);
        if (pos == 1) return seg_of(t);
        return seg_of(u);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            fails++;
            $display("FAIL wait_idle: busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic check_pop(input string name);
        logic [11:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: scoreboard empty, bcd_out=%h", name, bcd_out);
        end else begin
            e = exp_q.pop_front();
            if (bcd_out !== e) begin
                fails++;
                $display("FAIL %s: bcd_out=%h required %h", name, bcd_out, e);
            end
        end
    endtask

    task automatic check_scan(input string name, input logic [11:0] b);
        logic [2:0] prev;
        logic [2:0] ea;
        bit found = 1'b0;
        prev = an;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (prev == 3'b011 && an == 3'b110) found = 1'b1;
            prev = an;
        end
        checks++;
        if (!found) begin
            fails++;
            $display("FAIL %s_sync: no 011->110 anode transition, an=%b", name, an);
        end else begin
            for (int j = 0; j < 12; j++) begin
                ea = (j / 4 == 0) ? 3'b110 : (j / 4 == 1) ? 3'b101 : 3'b011;
                checks++;
                if (an !== ea) begin
                    fails++;
                    $display("FAIL %s_an[%0d]: an=%b required %b", name, j, an, ea);
                end
                checks++;
                if (seg !== exp_seg(b, j / 4)) begin
                    fails++;
                    $display("FAIL %s_seg[%0d]: seg=%b required %b", name, j, seg, exp_seg(b, j / 4));
                end
                tick();
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        value_in = 8'd0;
        tick();
        tick();
        checks++;
        if (an !== 3'b110 || seg !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_disp: an=%b seg=%b required 110 1000000", an, seg);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL reset_busy[%0d]: busy=%b required 0", i, busy);
            end
        end
        checks++;
        if (bcd_out !== 12'h000) begin
            fails++;
            $display("FAIL reset_bcd: bcd_out=%h required 000", bcd_out);
        end
    endtask

    task automatic test_max();
        int n;
        value_in = 8'hFF;
        exp_q.push_back(12'h255);
        tick();
        wait_idle(n);
        checks++;
        if (n != 8) begin
            fails++;
            $display("FAIL max_busy_len: busy cycles=%0d required 8", n);
        end
        check_pop("max_result");
    endtask

    task automatic test_scan();
        int n;
        value_in = 8'd123;
        exp_q.push_back(12'h123);
        tick();
        wait_idle(n);
        check_pop("scan_result");
        check_scan("scan123", 12'h123);
    endtask

    task automatic test_back_to_back();
        int n;
        value_in = 8'd200;
        exp_q.push_back(12'h200);
        tick();
        tick(); tick(); tick();
        value_in = 8'd7;
        exp_q.push_back(12'h007);
        wait_idle(n);
        checks++;
        if (n != 5) begin
            fails++;
            $display("FAIL b2b_first_lat: cycles after k+3=%0d required 5", n);
        end
        check_pop("b2b_first");
        tick();
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_restart: busy=%b at k+9 required 1", busy);
        end
        wait_idle(n);
        checks++;
        if (n != 8) begin
            fails++;
            $display("FAIL b2b_second_lat: cycles=%0d required 8", n);
        end
        check_pop("b2b_second");
    endtask

    task automatic test_no_change();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL nochange_busy[%0d]: busy=%b required 0", i, busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        value_in = 8'd99;
        tick();
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || bcd_out !== 12'h000 || an !== 3'b110) begin
            fails++;
            $display("FAIL midrst_state: busy=%b bcd=%h an=%b required 0 000 110", busy, bcd_out, an);
        end
        rst = 1'b0;
        exp_q.push_back(12'h099);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL midrst_restart: busy=%b required 1", busy);
        end
        wait_idle(n);
        check_pop("midrst_result");
    endtask

    task automatic test_blank();
        int n;
        value_in = 8'd7;
        exp_q.push_back(12'h007);
        tick();
        wait_idle(n);
        check_pop("blank_result");
        check_scan("blank7", 12'h007);
    endtask

    initial begin
        test_reset();
        test_max();
        test_scan();
        test_back_to_back();
        test_no_change();
        test_reset_mid();
        test_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
